// File: rtl/racod_pkg.sv
// Shared constants and types for the collision-check query front-end:
// pose field layout of the 192-bit config word and the dispatcher FSM encoding.
package racod_pkg;

  localparam int CFG_W        = 192;
  localparam int FIELD_W      = 32;
  localparam int ORIGIN_X_LSB = 160;
  localparam int ORIGIN_Y_LSB = 128;
  localparam int LENGTH_LSB   = 96;
  localparam int WIDTH_LSB    = 64;
  localparam int SIN_LSB      = 32;
  localparam int COS_LSB      = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/racod_query_fifo.sv
// Circular query buffer with occupancy count; head entry is visible combinationally.
// One-cycle write latency; the caller never pushes when full nor pops when empty.
module racod_query_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset; only pointers and count carry meaning after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

endmodule

// File: rtl/racod_query_dispatcher.sv
// Buffers tagged pose queries, issues them one at a time to the collision datapath,
// and returns {tag, collision} in arrival order; a stalled response holds off further issues.
module racod_query_dispatcher
  import racod_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 4,
  parameter int RESULT_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CFG_W-1:0]       req_data,
  input  logic [TAG_W-1:0]       req_tag,
  output logic [CFG_W-1:0]       cfg_data,
  output logic                   cfg_valid,
  input  logic                   collision,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_collision,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int ENT_W = CFG_W + TAG_W;
  localparam int LAT_W = $clog2(RESULT_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESULT_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  dispatch_state_t  state;
  logic [LAT_W-1:0] wait_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             last_wait;
  logic [ENT_W-1:0] head;
  logic [TAG_W-1:0] head_tag;
  logic [CFG_W-1:0] head_pose;

  assign head_tag  = head[ENT_W-1:CFG_W];
  assign head_pose = head[CFG_W-1:0];
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign last_wait = (state == ST_WAIT) && (wait_cnt == LAT_ONE);
  // The head stays in the FIFO while in flight so its tag is still available when the result lands.
  assign pop       = last_wait;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  racod_query_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({req_tag, req_data}),
    .pop       (pop),
    .head      (head),
    .count     (q_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      cfg_valid     <= 1'b0;
      cfg_data      <= '0;
      rsp_valid     <= 1'b0;
      rsp_collision <= 1'b0;
      rsp_tag       <= '0;
    end else begin
      cfg_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state     <= ST_ISSUE;
            cfg_valid <= 1'b1;
            cfg_data  <= head_pose;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= LAT_LOAD;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - LAT_ONE;
          if (last_wait) begin
            rsp_collision <= collision;
            rsp_tag       <= head_tag;
            rsp_valid     <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Skip IDLE when more work is queued so back-to-back queries keep the minimum spacing.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!fifo_empty) begin
              state     <= ST_ISSUE;
              cfg_valid <= 1'b1;
              cfg_data  <= head_pose;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_racod_query_dispatcher.sv
// Randomized bench for racod_query_dispatcher: timing-level reference model plus a
// stand-in datapath whose collision output is only correct RESULT_LAT cycles after cfg_valid.
module tb_racod_query_dispatcher;
  import racod_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int LAT   = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [CFG_W-1:0] req_data;
  logic [TAG_W-1:0] req_tag;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_valid;
  logic             collision = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_collision;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [CW-1:0]    q_count;

  always #5 clk = ~clk;

  racod_query_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .RESULT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .collision(collision), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_collision(rsp_collision), .rsp_tag(rsp_tag), .busy(busy), .q_count(q_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CFG_W-1:0] mk_pose(input logic [31:0] x, input logic [31:0] y,
      input logic [31:0] len, input logic [31:0] wid, input logic [31:0] s, input logic [31:0] c);
    return {x, y, len, wid, s, c};
  endfunction

  // ---------------- reference model (cycle-timed, queue based) ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [CFG_W-1:0] pose;
  } ent_t;

  ent_t             pend[$];
  ent_t             rsp_e;
  bit               m_inflight = 0;
  bit               m_resp     = 0;
  int               m_cnt      = 0;
  int               cnt_prev;
  bit               pushed;
  longint           cyc        = 0;
  longint           cfg_cyc    = -1;
  longint           rsp_cyc    = -1;
  logic [CFG_W-1:0] m_last_pose = '0;

  function automatic void m_issue();
    cfg_cyc     = cyc;
    rsp_cyc     = cyc + LAT + 1;
    m_inflight  = 1;
    m_last_pose = pend[0].pose;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend.delete();
      m_inflight  = 0;
      m_resp      = 0;
      m_cnt       = 0;
      cfg_cyc     = -1;
      rsp_cyc     = -1;
      m_last_pose = '0;
    end else begin
      cnt_prev = m_cnt;
      pushed   = req_valid && (cnt_prev != DEPTH);
      if (m_inflight && cyc == rsp_cyc) begin
        rsp_e      = pend.pop_front();
        m_cnt--;
        m_inflight = 0;
        m_resp     = 1;
      end else if (m_resp) begin
        if (rsp_ready) begin
          m_resp = 0;
          if (cnt_prev > 0) m_issue();
        end
      end else if (!m_inflight && cnt_prev > 0) begin
        m_issue();
      end
      if (pushed) begin
        pend.push_back('{tag: req_tag, pose: req_data});
        m_cnt++;
      end
    end
  end

  // ---------------- monitor + downstream datapath stand-in ----------------
  bit               mon_en = 0;
  bit               prev_rv = 0;
  longint           cfg_seen = 0;
  int               since = 1000;
  logic [CFG_W-1:0] lat_pose = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("cfg_valid", cfg_valid, cyc == cfg_cyc);
      check_eq("cfg_data", cfg_data, m_last_pose);
      check_eq("rsp_valid", rsp_valid, m_resp);
      if (m_resp) begin
        check_eq("rsp_tag", rsp_tag, rsp_e.tag);
        check_eq("rsp_collision", rsp_collision, ^rsp_e.pose);
      end
      check_eq("q_count", q_count, m_cnt);
      check_eq("req_ready", req_ready, m_cnt != DEPTH);
      check_eq("busy", busy, m_inflight || m_resp || m_cnt > 0);
      if (cfg_valid) cfg_seen = cyc;
      if (rsp_valid && !prev_rv && !rst) check_eq("rsp_latency", cyc - cfg_seen, LAT + 1);
      prev_rv = rsp_valid;
    end
    // Result is only right exactly LAT cycles after the write; any other sample sees it inverted.
    if (cfg_valid) begin
      lat_pose = cfg_data;
      since    = 0;
    end else if (since < 1000) begin
      since++;
    end
    collision = (since == LAT) ? ^lat_pose : ~^lat_pose;
  end

  // ---------------- stimulus helpers ----------------
  bit rand_rdy = 0;

  always @(negedge clk) begin
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [TAG_W-1:0] t, input logic [CFG_W-1:0] p);
    int  budget;
    bit  ok;
    budget    = 300;
    req_valid = 1'b1;
    req_tag   = t;
    req_data  = p;
    ok        = 0;
    while (!ok && budget > 0) begin
      ok = req_ready;
      @(negedge clk);
      budget--;
    end
    if (!ok) check_eq("push_timeout", req_ready, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 500;
    while ((m_inflight || m_resp || m_cnt > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check_eq("drain_timeout", busy, 1'b0);
  endtask

  logic [CFG_W-1:0] pose_hit;
  logic [CFG_W-1:0] pose_miss;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    pose_hit  = mk_pose(0, 0, 0, 0, 0, 1);
    pose_miss = mk_pose(0, 1, 0, 0, 8, 0);
    rst = 1'b1; req_valid = 1'b0; req_tag = '0; req_data = '0; rsp_ready = 1'b1;
    @(posedge clk);
    mon_en = 1;
    repeat (2) @(negedge clk);
    check_eq("rst_q_count", q_count, 0);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_cfg_data", cfg_data, 0);
    check_eq("rst_rsp_tag", rsp_tag, 0);
    check_eq("rst_rsp_collision", rsp_collision, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;

    // single collide / no-collide queries
    send(4'd3, pose_hit);
    wait_idle();
    send(4'd5, pose_miss);
    wait_idle();

    // back-to-back burst
    for (int i = 1; i <= 4; i++) send(TAG_W'(i), (i % 2) ? pose_hit : pose_miss);
    wait_idle();

    // stalled consumer: FIFO fills, no issues while the response waits
    rsp_ready = 1'b0;
    for (int i = 8; i <= 12; i++) send(TAG_W'(i), (i % 2) ? pose_hit : pose_miss);
    fork
      send(4'd13, pose_hit);
      begin
        repeat (12) @(negedge clk);
        check_eq("stall_q_count", q_count, 4);
        check_eq("stall_req_ready", req_ready, 0);
        check_eq("stall_rsp_tag", rsp_tag, 8);
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // reset while a query is in WAIT with more queued
    send(4'd1, pose_hit);
    send(4'd2, pose_miss);
    send(4'd3, pose_hit);
    b = 50;
    while (!cfg_valid && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (b == 0) check_eq("issue_timeout", cfg_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_q_count", q_count, 0);
    check_eq("mid_rst_rsp_valid", rsp_valid, 0);
    check_eq("mid_rst_cfg_valid", cfg_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    send(4'd7, pose_miss);
    wait_idle();

    // randomized traffic with random consumer backpressure
    rand_rdy = 1;
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(TAG_W'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    end
    rand_rdy = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
